// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg
// Shared types and constants for the RAM port arbiter slice.
//   arb_state_t : debug-side transaction state (idle / waiting for grant / holding ack)
//   SEL_WORD    : byte-enable pattern used for every debug access (always full words)
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_ACK
  } arb_state_t;

  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the three buses around the arbiter: the CPU MEM-stage port, the
// four-phase debug/loader port, and the single-port RAM port.
//   modport slave  : the arbiter's view (consumes CPU/debug requests, drives the RAM)
//   modport master : the surrounding system's view (CPU, debug host and RAM)
// Parameter ADDR_BITS is the byte-address width; word addresses are ADDR_BITS-2 bits.
interface ram_port_arbiter_if #(
  parameter int ADDR_BITS = 12
);

  // CPU MEM stage
  logic                 cpu_req;
  logic                 cpu_rw;
  logic [ADDR_BITS-3:0] cpu_addr;
  logic [3:0]           cpu_sel;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;

  // Debug / loader port
  logic                 dbg_req;
  logic                 dbg_rw;
  logic [ADDR_BITS-3:0] dbg_addr;
  logic [31:0]          dbg_wdata;
  logic                 dbg_ack;
  logic [31:0]          dbg_rdata;

  // RAM port
  logic [ADDR_BITS-3:0] ram_addr;
  logic [31:0]          ram_data_in;
  logic [3:0]           ram_sel;
  logic                 ram_rw;
  logic [31:0]          ram_data_out;

  // Statistics
  logic [31:0]          conflict_cycles;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_sel, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_rw, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output ram_addr, ram_data_in, ram_sel, ram_rw,
    input  ram_data_out,
    output conflict_cycles
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_sel, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_rw, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  ram_addr, ram_data_in, ram_sel, ram_rw,
    output ram_data_out,
    input  conflict_cycles
  );

endinterface

// File: rtl/ram_port_arbiter_counter.sv
// Counter
// Free-running up-counter with enable; wraps at 2^WIDTH.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   en    : count this cycle
//   count : current value
module Counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single-port data RAM between the CPU MEM stage (priority) and a
// four-phase debug/loader port. A starvation counter forces a debug grant after
// STARVE_LIMIT denied cycles, stalling the CPU for exactly that one cycle.
//   clk  : system clock
//   rst  : asynchronous active-high reset; aborts any pending debug transaction
//   bus  : ram_port_arbiter_if.slave carrying the CPU, debug and RAM ports plus
//          the conflict_cycles statistic (cycles with cpu_stall=1)
// Parameters: ADDR_BITS (byte-address width), STARVE_LIMIT (>=1).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  ram_port_arbiter_if.slave   bus
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t           state;
  arb_state_t           next_state;

  logic                 pend_rw;
  logic [ADDR_BITS-3:0] pend_addr;
  logic [31:0]          pend_wdata;
  logic [CNT_W-1:0]     starve_cnt;
  logic                 dbg_ack_q;
  logic [31:0]          dbg_rdata_q;
  logic                 serve_dbg;
  logic                 cpu_stall_int;
  logic [31:0]          conflict_cnt;

  // Debug owns the RAM this cycle if the CPU is idle or has starved it long enough.
  assign serve_dbg = (state == ARB_WAIT) && (!bus.cpu_req || (starve_cnt == LIMIT));

  assign bus.cpu_rdata       = bus.ram_data_out;
  assign bus.cpu_stall       = cpu_stall_int;
  assign bus.dbg_ack         = dbg_ack_q;
  assign bus.dbg_rdata       = dbg_rdata_q;
  assign bus.conflict_cycles = conflict_cnt;

  // Grant select: CPU fields by default, pending debug fields on a serve cycle.
  // An idle CPU still drives address/data but must never write.
  always_comb begin
    bus.ram_addr    = bus.cpu_addr;
    bus.ram_data_in = bus.cpu_wdata;
    bus.ram_sel     = bus.cpu_sel;
    bus.ram_rw      = bus.cpu_req & bus.cpu_rw;
    cpu_stall_int   = 1'b0;
    if (serve_dbg) begin
      bus.ram_addr    = pend_addr;
      bus.ram_data_in = pend_wdata;
      bus.ram_sel     = SEL_WORD;
      bus.ram_rw      = pend_rw;
      cpu_stall_int   = bus.cpu_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ACK only releases on a sampled dbg_req=0, so a request dropped early in
  // WAIT still completes and then holds the ack for a single cycle.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (bus.dbg_req) next_state = ARB_WAIT;
      ARB_WAIT: if (serve_dbg)   next_state = ARB_ACK;
      ARB_ACK:  if (!bus.dbg_req) next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Debug datapath: request capture, starvation count, read-data and ack registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rw     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      starve_cnt  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (bus.dbg_req) begin
            pend_rw    <= bus.dbg_rw;
            pend_addr  <= bus.dbg_addr;
            pend_wdata <= bus.dbg_wdata;
            starve_cnt <= '0;
          end
        end
        ARB_WAIT: begin
          if (serve_dbg) begin
            if (!pend_rw) begin
              dbg_rdata_q <= bus.ram_data_out;
            end
            dbg_ack_q  <= 1'b1;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        ARB_ACK: begin
          if (!bus.dbg_req) begin
            dbg_ack_q <= 1'b0;
          end
        end
        default: begin
          dbg_ack_q <= 1'b0;
        end
      endcase
    end
  end

  Counter #(
    .WIDTH(32)
  ) u_conflict_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cpu_stall_int),
    .count (conflict_cnt)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a behavioural asynchronous-read RAM.
// Inputs change on the falling edge; outputs are sampled 1 time unit after an edge.
// Expected read data and expected stall timing go through a scoreboard queue.
module tb_ram_port_arbiter;

  localparam int ADDR_BITS    = 12;
  localparam int STARVE_LIMIT = 8;

  logic clk;
  logic rst;

  ram_port_arbiter_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  ram_port_arbiter #(
    .ADDR_BITS    (ADDR_BITS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, byte-enabled synchronous write.
  logic [31:0] mem [0:(1 << (ADDR_BITS - 2)) - 1];
  assign bus.ram_data_out = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (bus.ram_rw) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_sel[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_data_in[8*b +: 8];
      end
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected scoreboard entry, queue empty", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      check_output(tag, observed, expected);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic rw, input logic [ADDR_BITS-3:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_sel   = sel;
    bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic rw, input logic [ADDR_BITS-3:0] addr,
                           input logic [31:0] wdata);
    bus.dbg_req   = req;
    bus.dbg_rw    = rw;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cycle;
    int   stalls;
    int   i_cpu;
    bit   ack_seen;
    logic stalled;

    rst = 1'b1;
    drive_cpu(1'b0, 1'b1, '0, 4'h0, '0);
    drive_dbg(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_dbg_ack",   32'(bus.dbg_ack), 32'd0);
    check_output("reset_dbg_rdata", bus.dbg_rdata, 32'd0);
    check_output("reset_conflicts", bus.conflict_cycles, 32'd0);
    check_output("reset_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check_output("idle_cpu_ram_rw", 32'(bus.ram_rw), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CPU only: full-word store/load, then a half-word store to check byte enables.
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    #1;
    check_output("cpu_store_stall", 32'(bus.cpu_stall), 32'd0);
    check_output("cpu_store_ram_rw", 32'(bus.ram_rw), 32'd1);
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 10'd5, 4'hF, '0);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    check_pop("cpu_load_w5", bus.cpu_rdata);
    check_output("cpu_load_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd5, 4'b0011, 32'h0000CAFE);
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 10'd5, 4'hF, '0);
    exp_q.push_back(32'hDEADCAFE);
    #1;
    check_pop("cpu_load_w5_bytes", bus.cpu_rdata);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    #1;
    check_output("cpu_only_conflicts", bus.conflict_cycles, 32'd0);

    // Debug read with idle CPU: ack two edges after the request edge.
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd3, 4'hF, 32'h12345678);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    drive_dbg(1'b1, 1'b0, 10'd3, '0);
    exp_q.push_back(32'h12345678);
    edge_sample();
    check_output("dbg_rd_ack_edge1", 32'(bus.dbg_ack), 32'd0);
    check_output("dbg_rd_ram_sel", 32'(bus.ram_sel), 32'hF);
    check_output("dbg_rd_ram_addr", 32'(bus.ram_addr), 32'd3);
    check_output("dbg_rd_ram_rw", 32'(bus.ram_rw), 32'd0);
    check_output("dbg_rd_stall_idle_cpu", 32'(bus.cpu_stall), 32'd0);
    edge_sample();
    check_output("dbg_rd_ack_edge2", 32'(bus.dbg_ack), 32'd1);
    check_pop("dbg_rd_data_w3", bus.dbg_rdata);
    edge_sample();
    check_output("dbg_rd_ack_held", 32'(bus.dbg_ack), 32'd1);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    edge_sample();
    check_output("dbg_rd_ack_drop", 32'(bus.dbg_ack), 32'd0);

    // Starvation: CPU stores every cycle; a stalled access is re-presented next cycle.
    @(negedge clk);
    i_cpu = 0;
    drive_dbg(1'b1, 1'b1, 10'd9, 32'hA5A5A5A5);
    drive_cpu(1'b1, 1'b1, 10'(40 + i_cpu), 4'hF, 32'hC0DE0000 + 32'(i_cpu));
    exp_q.push_back(32'(STARVE_LIMIT + 1));
    cycle    = 0;
    stalls   = 0;
    ack_seen = 1'b0;
    while (!ack_seen && cycle < 30) begin
      #1;
      stalled = bus.cpu_stall;
      if (stalled) begin
        stalls++;
        check_pop("starve_stall_cycle", 32'(cycle));
        check_output("starve_ram_addr", 32'(bus.ram_addr), 32'd9);
        check_output("starve_ram_wdata", bus.ram_data_in, 32'hA5A5A5A5);
        check_output("starve_ram_rw", 32'(bus.ram_rw), 32'd1);
      end
      edge_sample();
      if (bus.dbg_ack) begin
        ack_seen = 1'b1;
        check_output("starve_ack_cycle", 32'(cycle), 32'(STARVE_LIMIT + 1));
      end
      @(negedge clk);
      if (!stalled) i_cpu++;
      cycle++;
      drive_cpu(1'b1, 1'b1, 10'(40 + i_cpu), 4'hF, 32'hC0DE0000 + 32'(i_cpu));
    end
    check_output("starve_ack_seen", 32'(ack_seen), 32'd1);
    check_output("starve_stall_count", 32'(stalls), 32'd1);
    drive_dbg(1'b0, 1'b0, '0, '0);
    edge_sample();
    check_output("starve_ack_drop", 32'(bus.dbg_ack), 32'd0);
    check_output("starve_conflicts", bus.conflict_cycles, 32'd1);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    check_output("starve_w9", mem[9], 32'hA5A5A5A5);
    for (int j = 0; j <= i_cpu; j++) begin
      check_output($sformatf("starve_cpu_w%0d", 40 + j), mem[40 + j], 32'hC0DE0000 + 32'(j));
    end

    // Same-address race: CPU wins the first cycle, debug write lands next.
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd7, 4'hF, 32'h1);
    drive_dbg(1'b1, 1'b1, 10'd7, 32'h2);
    edge_sample();
    check_output("race_w7_after_cpu", mem[7], 32'h1);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    edge_sample();
    check_output("race_w7_after_dbg", mem[7], 32'h2);
    check_output("race_ack", 32'(bus.dbg_ack), 32'd1);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    edge_sample();
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 10'd7, 4'hF, '0);
    exp_q.push_back(32'h2);
    #1;
    check_pop("race_cpu_load_w7", bus.cpu_rdata);

    // Reset while a debug write waits behind CPU traffic.
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd11, 4'hF, 32'h55);
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 10'd60, 4'hF, 32'h600D);
    drive_dbg(1'b1, 1'b1, 10'd11, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_dbg(1'b0, 1'b0, '0, '0);
    drive_cpu(1'b0, 1'b0, '0, 4'h0, '0);
    #1;
    check_output("rst_wait_ack", 32'(bus.dbg_ack), 32'd0);
    check_output("rst_wait_conflicts", bus.conflict_cycles, 32'd0);
    check_output("rst_wait_dbg_rdata", bus.dbg_rdata, 32'd0);
    check_output("rst_wait_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) edge_sample();
    check_output("rst_wait_w11_kept", mem[11], 32'h55);
    @(negedge clk);
    drive_dbg(1'b1, 1'b0, 10'd11, '0);
    exp_q.push_back(32'h55);
    edge_sample();
    check_output("post_rst_ack_edge1", 32'(bus.dbg_ack), 32'd0);
    edge_sample();
    check_output("post_rst_ack_edge2", 32'(bus.dbg_ack), 32'd1);
    check_pop("post_rst_rdata_w11", bus.dbg_rdata);
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, '0, '0);
    edge_sample();
    check_output("post_rst_ack_drop", 32'(bus.dbg_ack), 32'd0);
    check_output("post_rst_conflicts", bus.conflict_cycles, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
